// File: rtl/seq_divider_if.sv
// Launch/result bundle between the execute stage and the iterative divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, cancel, is_signed, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, cancel, is_signed, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, fixed
// WIDTH+2 cycle latency, MIPS sign rules, quotient to LO and remainder to HI.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_b,
  seq_divider_if.slave  dif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] araw_q, araw_d;   // original dividend for divide-by-zero
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic             accept;

  assign a_mag = (dif.is_signed && dif.a[WIDTH-1]) ? -dif.a : dif.a;
  assign b_mag = (dif.is_signed && dif.b[WIDTH-1]) ? -dif.b : dif.b;

  // Trial subtract of the shifted partial remainder; top bit is the borrow.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};
  assign borrow  = trial[WIDTH+1];

  // cancel in IDLE is a no-op but still blocks a same-edge start.
  assign accept = dif.start && !dif.cancel && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    araw_d  = araw_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;

    if (dif.cancel && state_q != IDLE) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      rem_d   = '0;
      dvd_d   = a_mag;
      dvs_d   = b_mag;
      araw_d  = dif.a;
      negq_d  = dif.is_signed & (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
      negr_d  = dif.is_signed & dif.a[WIDTH-1];
      dbz_d   = (dif.b == '0);
    end else begin
      case (state_q)
        RUN: begin
          rem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
        FIX: begin
          // Zero divisor bypasses the sign fix so remainder is the raw dividend.
          if (dbz_q) begin
            quo_d = '1;
            rmd_d = araw_q;
          end else begin
            quo_d = negq_q ? -dvd_q : dvd_q;
            rmd_d = negr_q ? -rem_q : rem_q;
          end
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      araw_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      araw_q  <= araw_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
    end
  end

  assign dif.busy        = (state_q == RUN) || (state_q == FIX);
  assign dif.done        = (state_q == DONE);
  assign dif.quotient    = quo_q;
  assign dif.remainder   = rmd_q;
  assign dif.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_seq_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) dif ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .reset_b(reset_b), .dif(dif));

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  typedef struct packed {
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_b && dif.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got done=1, expected no pending result at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", dif.quotient, mon_e.q);
        chk("remainder", dif.remainder, mon_e.r);
        chk("div_by_zero", 32'(dif.div_by_zero), 32'(mon_e.dbz));
      end
    end
  end

  task automatic launch(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    dif.is_signed = sg;
    dif.a         = a;
    dif.b         = b;
    dif.start     = 1'b1;
    @(negedge clk);
    dif.start     = 1'b0;
  endtask

  // Called at negedge k0 after the start edge; returns the negedge index of done.
  task automatic wait_done(input int k0, output int lat, output int bc);
    lat = k0;
    bc  = 0;
    while (dif.done !== 1'b1 && lat < 100) begin
      if (dif.busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc;
    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    vecs[4] = '{1'b1, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
    vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[7] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b0};
    vecs[8] = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
    vecs[9] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};

    dif.start = 1'b0; dif.cancel = 1'b0; dif.is_signed = 1'b0; dif.a = '0; dif.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_quotient", dif.quotient, 32'd0);
    chk("rst_remainder", dif.remainder, 32'd0);
    chk("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].sg, vecs[i].a, vecs[i].b);
      sb.push_back('{vecs[i].q, vecs[i].r, vecs[i].dbz});
      wait_done(1, lat, bc);
      chk($sformatf("latency_v%0d", i), 32'(lat), 32'd34);
      chk($sformatf("busy_cycles_v%0d", i), 32'(bc), 32'd33);
      @(negedge clk);
    end

    // start mid-operation must be ignored
    launch(1'b0, 32'd1000, 32'd10);
    sb.push_back('{32'd100, 32'd0, 1'b0});
    repeat (8) @(negedge clk);
    dif.a = 32'd5; dif.b = 32'd1; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done(10, lat, bc);
    chk("latency_ignored_start", 32'(lat), 32'd34);
    repeat (40) @(negedge clk);

    // start in the DONE cycle runs back to back
    launch(1'b0, 32'd20, 32'd6);
    sb.push_back('{32'd3, 32'd2, 1'b0});
    wait_done(1, lat, bc);
    chk("latency_b2b_first", 32'(lat), 32'd34);
    launch(1'b0, 32'd17, 32'd4);
    sb.push_back('{32'd4, 32'd1, 1'b0});
    wait_done(1, lat, bc);
    chk("latency_b2b_second", 32'(lat), 32'd34);
    @(negedge clk);

    // cancel at cycle 15: no done, outputs keep 17/4 result
    launch(1'b0, 32'd50, 32'd5);
    repeat (13) @(negedge clk);
    dif.cancel = 1'b1;
    @(negedge clk);
    dif.cancel = 1'b0;
    chk("cancel_busy", 32'(dif.busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("cancel_quotient", dif.quotient, 32'd4);
    chk("cancel_remainder", dif.remainder, 32'd1);
    chk("cancel_dbz", 32'(dif.div_by_zero), 32'd0);

    // asynchronous reset mid-RUN
    launch(1'b1, 32'hFFFFFFF0, 32'd0);
    repeat (10) @(negedge clk);
    chk("pre_reset_dbz", 32'(dif.div_by_zero), 32'd1);
    chk("pre_reset_busy", 32'(dif.busy), 32'd1);
    #2 reset_b = 1'b0;
    #1;
    chk("arst_busy", 32'(dif.busy), 32'd0);
    chk("arst_done", 32'(dif.done), 32'd0);
    chk("arst_quotient", dif.quotient, 32'd0);
    chk("arst_remainder", dif.remainder, 32'd0);
    chk("arst_dbz", 32'(dif.div_by_zero), 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (40) @(negedge clk);

    launch(1'b0, 32'd12, 32'd4);
    sb.push_back('{32'd3, 32'd0, 1'b0});
    wait_done(1, lat, bc);
    chk("latency_after_reset", 32'(lat), 32'd34);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
